// File: rtl/vga_sync_if.sv
// Pixel-coordinate and sync bundle from the VGA timing generator to its consumers.
interface vga_sync_if;
    logic       p_tick;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       refresh_tick;
    logic [7:0] frame_cnt;

    modport master (
        output p_tick, pix_x, pix_y, video_on, hsync, vsync, refresh_tick, frame_cnt
    );

    modport slave (
        input  p_tick, pix_x, pix_y, video_on, hsync, vsync, refresh_tick, frame_cnt
    );
endinterface

// File: rtl/vga_sync.sv
// VGA timing generator: pixel-rate divider, scan counters, sync/blank decode.
// Optional macro VGA_SYNC_REG_EN moves hsync/vsync/video_on into flip-flops.
module vga_sync #(
    parameter int PIX_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(PIX_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP_C = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP_C = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FP + V_SYNC);
    localparam logic [9:0] V_REFR   = 10'(V_DISPLAY + 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_cnt_nxt_s;
    logic [9:0]       h_cnt_r;
    logic [9:0]       h_cnt_nxt_s;
    logic [9:0]       v_cnt_r;
    logic [9:0]       v_cnt_nxt_s;
    logic [7:0]       frame_cnt_r;
    logic [7:0]       frame_cnt_nxt_s;
    logic             p_tick_s;

    function automatic logic hsync_dec(input logic [9:0] h);
        hsync_dec = !((h >= HS_START) && (h < HS_END));
    endfunction

    function automatic logic vsync_dec(input logic [9:0] v);
        vsync_dec = !((v >= VS_START) && (v < VS_END));
    endfunction

    function automatic logic video_dec(input logic [9:0] h, input logic [9:0] v);
        video_dec = (h < H_DISP_C) && (v < V_DISP_C);
    endfunction

    assign p_tick_s = (div_cnt_r == DIV_LAST);

    // Next-state for divider and scan counters; ">=" folds any out-of-range value back to 0.
    always_comb begin
        div_cnt_nxt_s   = div_cnt_r;
        h_cnt_nxt_s     = h_cnt_r;
        v_cnt_nxt_s     = v_cnt_r;
        frame_cnt_nxt_s = frame_cnt_r;
        if (reset) begin
            div_cnt_nxt_s   = {DIV_W{1'b0}};
            h_cnt_nxt_s     = 10'd0;
            v_cnt_nxt_s     = 10'd0;
            frame_cnt_nxt_s = 8'd0;
        end else begin
            if (div_cnt_r >= DIV_LAST) begin
                div_cnt_nxt_s = {DIV_W{1'b0}};
            end else begin
                div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
            end
            if (p_tick_s) begin
                if (h_cnt_r >= H_LAST) begin
                    h_cnt_nxt_s = 10'd0;
                    if (v_cnt_r >= V_LAST) begin
                        v_cnt_nxt_s     = 10'd0;
                        frame_cnt_nxt_s = frame_cnt_r + 8'd1;
                    end else begin
                        v_cnt_nxt_s = v_cnt_r + 10'd1;
                    end
                end else begin
                    h_cnt_nxt_s = h_cnt_r + 10'd1;
                end
            end else begin
                h_cnt_nxt_s = h_cnt_r;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        div_cnt_r   <= div_cnt_nxt_s;
        h_cnt_r     <= h_cnt_nxt_s;
        v_cnt_r     <= v_cnt_nxt_s;
        frame_cnt_r <= frame_cnt_nxt_s;
    end

    assign vga.p_tick       = p_tick_s;
    assign vga.pix_x        = h_cnt_r;
    assign vga.pix_y        = v_cnt_r;
    assign vga.frame_cnt    = frame_cnt_r;
    assign vga.refresh_tick = p_tick_s && (h_cnt_r == 10'd0) && (v_cnt_r == V_REFR);

`ifdef VGA_SYNC_REG_EN
    logic hsync_r;
    logic vsync_r;
    logic video_on_r;

    // Decode from next-state counters so the flopped outputs line up with pix_x/pix_y.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_r    <= 1'b1;
            vsync_r    <= 1'b1;
            video_on_r <= 1'b1;
        end else begin
            hsync_r    <= hsync_dec(h_cnt_nxt_s);
            vsync_r    <= vsync_dec(v_cnt_nxt_s);
            video_on_r <= video_dec(h_cnt_nxt_s, v_cnt_nxt_s);
        end
    end

    assign vga.hsync    = hsync_r;
    assign vga.vsync    = vsync_r;
    assign vga.video_on = video_on_r;
`else
    assign vga.hsync    = hsync_dec(h_cnt_r);
    assign vga.vsync    = vsync_dec(v_cnt_r);
    assign vga.video_on = video_dec(h_cnt_r, v_cnt_r);
`endif
endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: full-size instance for line timing, and a
// shrunken-timing instance so whole frames fit in a short run.
module tb_vga_sync;
    logic clk;
    logic reset;
    logic reset_sm;

    int checks_cnt = 0;
    int errors_cnt = 0;

    vga_sync_if vif_main ();
    vga_sync_if vif_sm ();

    vga_sync u_main (
        .clk   (clk),
        .reset (reset),
        .vga   (vif_main)
    );

    // Small frame: H_TOTAL = 8, V_TOTAL = 9, 2 clks/pixel -> 144 clks per frame.
    vga_sync #(
        .PIX_DIV   (2),
        .H_DISPLAY (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_DISPLAY (4), .V_FP (2), .V_SYNC (1), .V_BP (2)
    ) u_sm (
        .clk   (clk),
        .reset (reset_sm),
        .vga   (vif_sm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int hs_low, hs_fall_x, hs_rise_x, vid_fall_x, vid_rise_x, vid_rise_y;
        int found, prev_hs, prev_vid;
        int refr_cnt, refr_bad, vs_low;

        reset    = 1'b1;
        reset_sm = 1'b1;
        step();
        step();

        check_val("rst_p_tick",   vif_main.p_tick, 0);
        check_val("rst_pix_x",    vif_main.pix_x, 0);
        check_val("rst_pix_y",    vif_main.pix_y, 0);
        check_val("rst_hsync",    vif_main.hsync, 1);
        check_val("rst_vsync",    vif_main.vsync, 1);
        check_val("rst_video_on", vif_main.video_on, 1);
        check_val("rst_refresh",  vif_main.refresh_tick, 0);
        check_val("rst_frame",    vif_main.frame_cnt, 0);

        reset = 1'b0;
        // p_tick is high in the 4th and 8th cycle after release.
        for (int k = 1; k <= 8; k++) begin
            step();
            check_val($sformatf("p_tick_k%0d", k), vif_main.p_tick, (k == 3 || k == 7) ? 1 : 0);
            check_val($sformatf("pix_x_k%0d", k), vif_main.pix_x, k / 4);
        end

        // One full line of observation starting at pix_x = 2.
        hs_low = 0; hs_fall_x = -1; hs_rise_x = -1;
        vid_fall_x = -1; vid_rise_x = -1; vid_rise_y = -1;
        prev_hs = vif_main.hsync;
        prev_vid = vif_main.video_on;
        for (int c = 0; c < 3200; c++) begin
            step();
            if (vif_main.hsync == 1'b0) hs_low++;
            if (prev_hs == 1 && vif_main.hsync == 1'b0) hs_fall_x = vif_main.pix_x;
            if (prev_hs == 0 && vif_main.hsync == 1'b1) hs_rise_x = vif_main.pix_x;
            if (prev_vid == 1 && vif_main.video_on == 1'b0) vid_fall_x = vif_main.pix_x;
            if (prev_vid == 0 && vif_main.video_on == 1'b1) begin
                vid_rise_x = vif_main.pix_x;
                vid_rise_y = vif_main.pix_y;
            end
            prev_hs = vif_main.hsync;
            prev_vid = vif_main.video_on;
        end
        check_val("hsync_low_clks", hs_low, 384);
        check_val("hsync_fall_x",   hs_fall_x, 656);
        check_val("hsync_rise_x",   hs_rise_x, 752);
        check_val("video_fall_x",   vid_fall_x, 640);
        check_val("video_rise_x",   vid_rise_x, 0);
        check_val("video_rise_y",   vid_rise_y, 1);

        // Line wrap from (799,9) to (0,10).
        found = 0;
        for (int c = 0; c < 40000 && found == 0; c++) begin
            step();
            if (vif_main.pix_x == 10'd799 && vif_main.pix_y == 10'd9 && vif_main.p_tick == 1'b1)
                found = 1;
        end
        check_val("wait_799_9", found, 1);
        step();
        check_val("wrap_pix_x", vif_main.pix_x, 0);
        check_val("wrap_pix_y", vif_main.pix_y, 10);
        check_val("wrap_vsync", vif_main.vsync, 1);

        // Mid-frame reset at pix_x = 300 with the divider at 2.
        found = 0;
        for (int c = 0; c < 4000 && found == 0; c++) begin
            step();
            if (vif_main.pix_x == 10'd299 && vif_main.p_tick == 1'b1) found = 1;
        end
        check_val("wait_299", found, 1);
        step();
        check_val("pre_rst_pix_x", vif_main.pix_x, 300);
        step();
        step();
        check_val("pre_rst_p_tick", vif_main.p_tick, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("mid_rst_pix_x",  vif_main.pix_x, 0);
        check_val("mid_rst_pix_y",  vif_main.pix_y, 0);
        check_val("mid_rst_hsync",  vif_main.hsync, 1);
        check_val("mid_rst_vsync",  vif_main.vsync, 1);
        check_val("mid_rst_frame",  vif_main.frame_cnt, 0);
        check_val("mid_rst_p_tick", vif_main.p_tick, 0);
        step();
        step();
        step();
        check_val("post_rst_p_tick", vif_main.p_tick, 1);

        // Three frames of the small instance: 432 clks.
        reset_sm = 1'b0;
        refr_cnt = 0; refr_bad = 0; vs_low = 0;
        for (int c = 1; c <= 432; c++) begin
            step();
            if (vif_sm.refresh_tick == 1'b1) begin
                refr_cnt++;
                if (vif_sm.pix_x != 10'd0 || vif_sm.pix_y != 10'd5) refr_bad++;
            end
            if (vif_sm.vsync == 1'b0) begin
                vs_low++;
                if (vif_sm.pix_y != 10'd6) refr_bad++;
            end
            if (c == 143) check_val("sm_frame_before_wrap", vif_sm.frame_cnt, 0);
            if (c == 144) begin
                check_val("sm_wrap_x", vif_sm.pix_x, 0);
                check_val("sm_wrap_y", vif_sm.pix_y, 0);
                check_val("sm_frame_after_wrap", vif_sm.frame_cnt, 1);
            end
        end
        check_val("sm_refresh_cnt",  refr_cnt, 3);
        check_val("sm_position_bad", refr_bad, 0);
        check_val("sm_vsync_low",    vs_low, 48);
        check_val("sm_frame_cnt",    vif_sm.frame_cnt, 3);
        check_val("sm_end_x",        vif_sm.pix_x, 0);
        check_val("sm_end_y",        vif_sm.pix_y, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
